conv_result_drain: RTL and testbench

CONV_RESULT_DRAIN -- requirements
Module: conv_result_drain

---
 rtl/conv_result_drain.sv | 124 ++++++++++++
 tb/tb_conv_result_drain.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_result_drain.sv
// Captures one convolution result frame and drains it one requantized element per handshake,
// in w-fastest order with matching (d,h,w) indices and a last-element flag.
module conv_result_drain #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RESULT_W   = 6,
  parameter int unsigned RESULT_H   = 6,
  parameter int unsigned RESULT_D   = 4,
  parameter int unsigned SHIFT      = 0,
  parameter int unsigned RELU       = 1,
  localparam int unsigned RES_WIDTH = 4 * DATA_WIDTH,
  localparam int unsigned N         = RESULT_D * RESULT_H * RESULT_W,
  localparam int unsigned DW        = (RESULT_D > 1) ? $clog2(RESULT_D) : 1,
  localparam int unsigned HW        = (RESULT_H > 1) ? $clog2(RESULT_H) : 1,
  localparam int unsigned WW        = (RESULT_W > 1) ? $clog2(RESULT_W) : 1,
  localparam int unsigned IW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N*RES_WIDTH-1:0]    result_data_in,
  input  logic [7:0]                opaque_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [DW-1:0]             out_d,
  output logic [HW-1:0]             out_h,
  output logic [WW-1:0]             out_w,
  output logic                      out_last,
  output logic [7:0]                out_opaque
);

  localparam logic signed [RES_WIDTH-1:0] SAT_MAX = RES_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [RES_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [DATA_WIDTH-1:0] SAT_MAX_D = DATA_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic [DATA_WIDTH-1:0] SAT_MIN_D = ~SAT_MAX_D;

  typedef enum logic {StIdle, StDrain} state_e;

  state_e                   r_state, w_state_d;
  logic [N*RES_WIDTH-1:0]   r_frame;
  logic [7:0]               r_opaque;
  logic [IW-1:0]            r_idx;
  logic [DW-1:0]            r_d;
  logic [HW-1:0]            r_h;
  logic [WW-1:0]            r_w;

  logic                     w_accept;
  logic                     w_at_last;
  logic signed [RES_WIDTH-1:0] w_elem;
  logic signed [RES_WIDTH-1:0] w_shift;
  logic signed [RES_WIDTH-1:0] w_relu;

  assign in_ready   = (r_state == StIdle);
  assign out_valid  = (r_state == StDrain);
  assign w_at_last  = (r_idx == IW'(N - 1));
  assign w_accept   = out_valid && out_ready;
  assign out_last   = out_valid && w_at_last;
  assign out_d      = r_d;
  assign out_h      = r_h;
  assign out_w      = r_w;
  assign out_opaque = r_opaque;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (in_valid) w_state_d = StDrain;
      StDrain: if (w_accept && w_at_last) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_frame  <= '0;
      r_opaque <= '0;
      r_idx    <= '0;
      r_d      <= '0;
      r_h      <= '0;
      r_w      <= '0;
    end else begin
      r_state <= w_state_d;
      if (r_state == StIdle && in_valid) begin
        r_frame  <= result_data_in;
        r_opaque <= opaque_in;
        r_idx    <= '0;
        r_d      <= '0;
        r_h      <= '0;
        r_w      <= '0;
      end else if (w_accept && !w_at_last) begin
        r_idx <= r_idx + IW'(1);
        // Nested wrap keeps (d,h,w) equal to the decomposition of r_idx.
        if (r_w == WW'(RESULT_W - 1)) begin
          r_w <= '0;
          if (r_h == HW'(RESULT_H - 1)) begin
            r_h <= '0;
            r_d <= r_d + DW'(1);
          end else begin
            r_h <= r_h + HW'(1);
          end
        end else begin
          r_w <= r_w + WW'(1);
        end
      end
    end
  end

  // Requantize: arithmetic shift, optional ReLU, then saturate to DATA_WIDTH signed.
  always_comb begin
    w_elem  = r_frame[r_idx*RES_WIDTH +: RES_WIDTH];
    w_shift = w_elem >>> SHIFT;
    w_relu  = w_shift;
    if (RELU != 0 && w_shift < 0) w_relu = '0;
    if (w_relu > SAT_MAX) begin
      out_data = SAT_MAX_D;
    end else if (w_relu < SAT_MIN) begin
      out_data = SAT_MIN_D;
    end else begin
      out_data = w_relu[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_conv_result_drain.sv
// Directed bench: three configurations of conv_result_drain checked against hand-computed tables
// for ordering, requantization, backpressure, handshake, reset and the single-element frame.
module tb_conv_result_drain;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Config A: D=2 H=1 W=2 SHIFT=0 RELU=0
  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_last;
  logic [127:0] a_data;
  logic [7:0]   a_op_in, a_op, a_out_data;
  logic [0:0]   a_d, a_h, a_w;

  conv_result_drain #(
    .DATA_WIDTH(8), .RESULT_W(2), .RESULT_H(1), .RESULT_D(2), .SHIFT(0), .RELU(0)
  ) u_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .result_data_in(a_data), .opaque_in(a_op_in), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_d(a_d), .out_h(a_h), .out_w(a_w),
    .out_last(a_last), .out_opaque(a_op)
  );

  // Config B: D=1 H=2 W=2 SHIFT=4 RELU=1
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_last;
  logic [127:0] b_data;
  logic [7:0]   b_op, b_out_data;
  logic [0:0]   b_d, b_h, b_w;

  conv_result_drain #(
    .DATA_WIDTH(8), .RESULT_W(2), .RESULT_H(2), .RESULT_D(1), .SHIFT(4), .RELU(1)
  ) u_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .result_data_in(b_data), .opaque_in(8'h11), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_d(b_d), .out_h(b_h), .out_w(b_w),
    .out_last(b_last), .out_opaque(b_op)
  );

  // Config C: single element, RELU=0
  logic         c_in_valid, c_in_ready, c_out_valid, c_last;
  logic [31:0]  c_data;
  logic [7:0]   c_op, c_out_data;
  logic [0:0]   c_d, c_h, c_w;

  conv_result_drain #(
    .DATA_WIDTH(8), .RESULT_W(1), .RESULT_H(1), .RESULT_D(1), .SHIFT(0), .RELU(0)
  ) u_c (
    .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .result_data_in(c_data), .opaque_in(8'h77), .out_valid(c_out_valid),
    .out_ready(1'b1), .out_data(c_out_data), .out_d(c_d), .out_h(c_h), .out_w(c_w),
    .out_last(c_last), .out_opaque(c_op)
  );

  typedef struct {
    logic signed [31:0] elem;
    int                 data;
    int                 d;
    int                 h;
    int                 w;
    bit                 last;
  } vec_t;

  vec_t tbl[4];
  int   exp_op;

  task automatic set_tbl(input int e0, input int x0, input int e1, input int x1,
                         input int e2, input int x2, input int e3, input int x3);
    int e[4];
    int x[4];
    e = '{e0, e1, e2, e3};
    x = '{x0, x1, x2, x3};
    for (int k = 0; k < 4; k++) begin
      tbl[k].elem = e[k];
      tbl[k].data = x[k];
      tbl[k].d    = k / 2;
      tbl[k].h    = 0;
      tbl[k].w    = k % 2;
      tbl[k].last = (k == 3);
    end
  endtask

  function automatic logic [127:0] pack_tbl();
    logic [127:0] f;
    for (int k = 0; k < 4; k++) f[k*32 +: 32] = tbl[k].elem;
    return f;
  endfunction

  task automatic check_elem(input int k);
    chk($sformatf("a[%0d] out_valid", k), int'(a_out_valid), 1);
    chk($sformatf("a[%0d] in_ready", k), int'(a_in_ready), 0);
    chk($sformatf("a[%0d] out_data", k), int'($signed(a_out_data)), tbl[k].data);
    chk($sformatf("a[%0d] out_d", k), int'(a_d), tbl[k].d);
    chk($sformatf("a[%0d] out_h", k), int'(a_h), tbl[k].h);
    chk($sformatf("a[%0d] out_w", k), int'(a_w), tbl[k].w);
    chk($sformatf("a[%0d] out_last", k), int'(a_last), int'(tbl[k].last));
    chk($sformatf("a[%0d] out_opaque", k), int'(a_op), exp_op);
  endtask

  // Called at a negedge; returns at the negedge after capture with element 0 presented.
  task automatic load_a(input bit hold);
    a_in_valid = 1'b1;
    a_data     = pack_tbl();
    a_op_in    = exp_op[7:0];
    @(negedge clk);
    a_in_valid = hold;
    a_data     = ~a_data;
    a_op_in    = ~a_op_in;
  endtask

  task automatic drain_a(input int stall_at);
    for (int k = 0; k < 4; k++) begin
      check_elem(k);
      if (k == stall_at) begin
        a_out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          check_elem(k);
        end
        a_out_ready = 1'b1;
      end
      @(negedge clk);
    end
    chk("a post-drain out_valid", int'(a_out_valid), 0);
    chk("a post-drain in_ready", int'(a_in_ready), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int b_elem[4];
    int b_exp[4];
    b_elem = '{-64, 32'h7FF, 48, -1};
    b_exp  = '{0, 127, 3, 0};
    a_in_valid = 0; a_out_ready = 1; a_data = '0; a_op_in = '0;
    b_in_valid = 0; b_out_ready = 1; b_data = '0;
    c_in_valid = 0; c_data = '0;

    // Reset state
    #3;
    chk("rst out_valid", int'(a_out_valid), 0);
    chk("rst in_ready", int'(a_in_ready), 1);
    chk("rst out_last", int'(a_last), 0);
    chk("rst out_data", int'(a_out_data), 0);
    chk("rst out_opaque", int'(a_op), 0);
    chk("rst idx", int'({a_d, a_h, a_w}), 0);
    chk("rst c out_last", int'(c_last), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post-rst in_ready", int'(a_in_ready), 1);
    chk("post-rst out_valid", int'(a_out_valid), 0);

    // Ordering and saturation
    set_tbl(5, 5, -3, -3, 127, 127, 200, 127);
    exp_op = 8'hA5;
    load_a(1'b0);
    drain_a(-1);

    // Backpressure on the second element
    exp_op = 8'h3C;
    load_a(1'b0);
    drain_a(1);

    // Handshake with in_valid held; frame 2 on the bus during frame 1 drain
    exp_op = 8'hA5;
    load_a(1'b1);
    set_tbl(-200, -128, 0, 0, 64, 64, -1, -1);
    a_data  = pack_tbl();
    a_op_in = 8'h5A;
    set_tbl(5, 5, -3, -3, 127, 127, 200, 127);
    drain_a(-1);
    set_tbl(-200, -128, 0, 0, 64, 64, -1, -1);
    exp_op = 8'h5A;
    @(negedge clk);
    a_in_valid = 1'b0;
    drain_a(-1);

    // Reset while at element 1
    set_tbl(5, 5, -3, -3, 127, 127, 200, 127);
    exp_op = 8'hC3;
    load_a(1'b0);
    check_elem(0);
    @(negedge clk);
    check_elem(1);
    #2 reset = 1'b1;
    #1;
    chk("mid-rst out_valid", int'(a_out_valid), 0);
    chk("mid-rst in_ready", int'(a_in_ready), 1);
    chk("mid-rst out_last", int'(a_last), 0);
    chk("mid-rst out_data", int'(a_out_data), 0);
    chk("mid-rst out_opaque", int'(a_op), 0);
    chk("mid-rst idx", int'({a_d, a_h, a_w}), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("after-rst out_valid", int'(a_out_valid), 0);
    exp_op = 8'h96;
    load_a(1'b0);
    drain_a(-1);

    // Requantization, SHIFT=4 RELU=1, with h wrap
    b_in_valid = 1'b1;
    for (int k = 0; k < 4; k++) b_data[k*32 +: 32] = b_elem[k];
    @(negedge clk);
    b_in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("b[%0d] out_valid", k), int'(b_out_valid), 1);
      chk($sformatf("b[%0d] out_data", k), int'($signed(b_out_data)), b_exp[k]);
      chk($sformatf("b[%0d] out_h", k), int'(b_h), k / 2);
      chk($sformatf("b[%0d] out_w", k), int'(b_w), k % 2);
      chk($sformatf("b[%0d] out_last", k), int'(b_last), int'(k == 3));
      chk($sformatf("b[%0d] out_opaque", k), int'(b_op), 8'h11);
      @(negedge clk);
    end
    chk("b post-drain out_valid", int'(b_out_valid), 0);
    chk("b post-drain in_ready", int'(b_in_ready), 1);

    // Single-element frame
    c_in_valid = 1'b1;
    c_data     = -32'sd5;
    @(negedge clk);
    c_in_valid = 1'b0;
    chk("c out_valid", int'(c_out_valid), 1);
    chk("c out_data", int'($signed(c_out_data)), -5);
    chk("c out_last", int'(c_last), 1);
    chk("c idx", int'({c_d, c_h, c_w}), 0);
    chk("c out_opaque", int'(c_op), 8'h77);
    @(negedge clk);
    chk("c post out_valid", int'(c_out_valid), 0);
    chk("c post in_ready", int'(c_in_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
